// File: rtl/circle_sched_pkg.sv
// circle_sched_pkg: shared box type, widths and the clamp/normalize helper for circle_slot_scheduler.
package circle_sched_pkg;
    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int BOX_W = 42;
    typedef struct packed {
        logic [X_W-1:0] x_min;
        logic [Y_W-1:0] y_min;
        logic [X_W-1:0] x_max;
        logic [Y_W-1:0] y_max;
    } circle_box_t;
    // Raw request boxes share the struct layout: {x_a, y_a, x_b, y_b}.
    function automatic circle_box_t clamp_sort_box(
        input logic [BOX_W-1:0] raw,
        input logic [X_W-1:0]   x_lim,
        input logic [Y_W-1:0]   y_lim
    );
        circle_box_t r;
        circle_box_t o;
        logic [X_W-1:0] xa;
        logic [X_W-1:0] xb;
        logic [Y_W-1:0] ya;
        logic [Y_W-1:0] yb;
        r = raw;
        xa = (r.x_min > x_lim) ? x_lim : r.x_min;
        xb = (r.x_max > x_lim) ? x_lim : r.x_max;
        ya = (r.y_min > y_lim) ? y_lim : r.y_min;
        yb = (r.y_max > y_lim) ? y_lim : r.y_max;
        o.x_min = (xa < xb) ? xa : xb;
        o.x_max = (xa < xb) ? xb : xa;
        o.y_min = (ya < yb) ? ya : yb;
        o.y_max = (ya < yb) ? yb : ya;
        return o;
    endfunction
endpackage

// File: rtl/circle_slot_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wraparound.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    int idx;
    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        grant = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (valid[idx]) grant = N'(1) << idx;
        end
    end
endmodule

// File: rtl/circle_slot_scheduler.sv
// circle_slot_scheduler: arbitrates requester box writes into a shadow slot table committed on frame start.
// Optional frame statistics ports are enabled by defining CIRCLE_SCHED_STATS_EN.
module circle_slot_scheduler
    import circle_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int NUM_SLOTS = 4,
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 frame_start_in,
    input  logic [NUM_REQ-1:0]                   req_valid_in,
    output logic [NUM_REQ-1:0]                   req_ready_out,
    input  logic [NUM_REQ*$clog2(NUM_SLOTS)-1:0] req_slot_in,
    input  logic [NUM_REQ-1:0]                   req_en_in,
    input  logic [NUM_REQ*BOX_W-1:0]             req_box_in,
    output logic [NUM_SLOTS*BOX_W-1:0]           slot_box_out,
`ifdef CIRCLE_SCHED_STATS_EN
    output logic [7:0]                           frame_writes_out,
    output logic                                 frame_collision_out,
`endif
    output logic [NUM_SLOTS-1:0]                 slot_valid_out
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [X_W-1:0] X_LIM = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(V_ACTIVE - 1);

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 xfer;
    logic                 sel_en;
    logic [SW-1:0]        sel_slot;
    logic [BOX_W-1:0]     sel_box;
    circle_box_t          shadow [NUM_SLOTS];
    circle_box_t          active [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] shadow_valid;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .valid(req_valid_in),
        .ptr  (rr_ptr),
        .grant(grant)
    );

    // Commit cycles and reset block every grant.
    assign req_ready_out = (rst_n_in && !frame_start_in) ? grant : '0;
    assign xfer = |(req_valid_in & req_ready_out);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) gnt_idx = grant[i] ? PW'(i) : gnt_idx;
        sel_slot = req_slot_in[gnt_idx*SW +: SW];
        sel_en = req_en_in[gnt_idx];
        sel_box = req_box_in[gnt_idx*BOX_W +: BOX_W];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr <= '0;
            shadow_valid <= '0;
            slot_valid_out <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                shadow[s] <= '0;
                active[s] <= '0;
            end
        end else begin
            if (xfer) begin
                rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                shadow_valid[sel_slot] <= sel_en;
                if (sel_en) shadow[sel_slot] <= clamp_sort_box(sel_box, X_LIM, Y_LIM);
            end
            if (frame_start_in) begin
                active <= shadow;
                slot_valid_out <= shadow_valid;
            end
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_out
        assign slot_box_out[s*BOX_W +: BOX_W] = active[s];
    end

`ifdef CIRCLE_SCHED_STATS_EN
    logic [7:0]         write_cnt;
    logic               collision;
    logic [NUM_REQ-1:0] writer [NUM_SLOTS];

    // Per-slot writer masks flag a second distinct requester touching a slot within one frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            write_cnt <= '0;
            collision <= 1'b0;
            frame_writes_out <= '0;
            frame_collision_out <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) writer[s] <= '0;
        end else if (frame_start_in) begin
            frame_writes_out <= write_cnt;
            frame_collision_out <= collision;
            write_cnt <= '0;
            collision <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) writer[s] <= '0;
        end else if (xfer) begin
            write_cnt <= (&write_cnt) ? write_cnt : write_cnt + 8'd1;
            collision <= collision | (|(writer[sel_slot] & ~grant));
            writer[sel_slot] <= writer[sel_slot] | grant;
        end
    end
`endif
endmodule

// File: tb/tb_circle_slot_scheduler.sv
// tb_circle_slot_scheduler: scoreboard bench for circle_slot_scheduler; checks stats when CIRCLE_SCHED_STATS_EN is defined.
module tb_circle_slot_scheduler;
    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         frame_start_in;
    logic [1:0]   req_valid_in;
    logic [1:0]   req_ready_out;
    logic [3:0]   req_slot_in;
    logic [1:0]   req_en_in;
    logic [83:0]  req_box_in;
    logic [167:0] slot_box_out;
    logic [3:0]   slot_valid_out;
    logic [7:0]   frame_writes_out;
    logic         frame_collision_out;

    typedef struct {
        logic [3:0]   v;
        logic [167:0] b;
        logic [7:0]   w;
        logic         c;
    } commit_t;

    commit_t    cq[$];
    logic [1:0] rq[$];
    commit_t    ce;
    logic [1:0] re;
    logic       commit_seen;
    int         errors = 0;
    int         checks = 0;

    circle_slot_scheduler dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .frame_start_in(frame_start_in),
        .req_valid_in(req_valid_in),
        .req_ready_out(req_ready_out),
        .req_slot_in(req_slot_in),
        .req_en_in(req_en_in),
        .req_box_in(req_box_in),
        .slot_box_out(slot_box_out),
`ifdef CIRCLE_SCHED_STATS_EN
        .frame_writes_out(frame_writes_out),
        .frame_collision_out(frame_collision_out),
`endif
        .slot_valid_out(slot_valid_out)
    );

`ifndef CIRCLE_SCHED_STATS_EN
    assign frame_writes_out = '0;
    assign frame_collision_out = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    function automatic logic [41:0] bx(input int a, input int b, input int c, input int d);
        return {11'(a), 10'(b), 11'(c), 10'(d)};
    endfunction

    function automatic logic [167:0] slots(input logic [41:0] s3, s2, s1, s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_rdy(input logic [1:0] r);
        rq.push_back(r);
    endtask

    task automatic push_commit(input logic [3:0] v, input logic [167:0] b, input int w, input logic c);
        commit_t e;
        e.v = v;
        e.b = b;
        e.w = 8'(w);
        e.c = c;
        cq.push_back(e);
    endtask

    always @(posedge clk_in or negedge rst_n_in) commit_seen <= rst_n_in ? frame_start_in : 1'b0;

    // Monitor: pops an expected grant whenever a grant decision is visible, and an expected bank after each commit.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (req_valid_in != 2'b00 || frame_start_in) begin
                if (rq.size() == 0) chk("ready_unexpected", 168'(req_ready_out), 168'h1ff);
                else begin
                    re = rq.pop_front();
                    chk("ready", 168'(req_ready_out), 168'(re));
                end
            end
            if (commit_seen) begin
                if (cq.size() == 0) chk("commit_unexpected", 168'(slot_valid_out), 168'h1ff);
                else begin
                    ce = cq.pop_front();
                    chk("slot_valid", 168'(slot_valid_out), 168'(ce.v));
                    chk("slot_box", slot_box_out, ce.b);
`ifdef CIRCLE_SCHED_STATS_EN
                    chk("frame_writes", 168'(frame_writes_out), 168'(ce.w));
                    chk("frame_collision", 168'(frame_collision_out), 168'(ce.c));
`endif
                end
            end
        end
    end

    logic [41:0] b0, b1, b2, b3, c0, c1;

    initial begin
        b0 = bx(1, 2, 3, 4);
        b1 = bx(5, 6, 7, 8);
        b2 = bx(100, 50, 300, 400);
        b3 = bx(10, 10, 1279, 719);
        c0 = bx(1, 1, 2, 2);
        c1 = bx(50, 60, 70, 80);
        rst_n_in = 1'b0;
        frame_start_in = 1'b0;
        req_valid_in = 2'b11;
        req_en_in = 2'b11;
        req_slot_in = {2'd3, 2'd2};
        req_box_in = {bx(2000, 900, 10, 10), bx(300, 400, 100, 50)};
        repeat (3) cyc();
        chk("rst_ready", 168'(req_ready_out), 168'(0));
        chk("rst_valid", 168'(slot_valid_out), 168'(0));
        chk("rst_box", slot_box_out, 168'(0));
`ifdef CIRCLE_SCHED_STATS_EN
        chk("rst_stats", 168'({frame_writes_out, frame_collision_out}), 168'(0));
`endif
        // Write slot 2 and a clamped slot 3; first grant after reset goes to requester 0.
        push_rdy(2'b01);
        #2 rst_n_in = 1'b1;
        cyc();
        push_rdy(2'b10);
        cyc();
        req_valid_in = 2'b00;
        chk("pre_commit_valid", 168'(slot_valid_out), 168'(0));
        chk("pre_commit_box", slot_box_out, 168'(0));
        frame_start_in = 1'b1;
        push_rdy(2'b00);
        push_commit(4'b1100, slots(b3, b2, 42'(0), 42'(0)), 2, 1'b0);
        cyc();
        frame_start_in = 1'b0;
        // Alternation with a commit cycle inserted mid-stream.
        req_slot_in = {2'd1, 2'd0};
        req_box_in = {bx(7, 8, 5, 6), bx(1, 2, 3, 4)};
        req_valid_in = 2'b11;
        push_rdy(2'b01);
        cyc();
        push_rdy(2'b10);
        cyc();
        push_rdy(2'b01);
        cyc();
        frame_start_in = 1'b1;
        push_rdy(2'b00);
        push_commit(4'b1111, slots(b3, b2, b1, b0), 3, 1'b0);
        cyc();
        frame_start_in = 1'b0;
        push_rdy(2'b10);
        cyc();
        push_rdy(2'b01);
        cyc();
        push_rdy(2'b10);
        cyc();
        // Clear slot 2 on the cycle right before frame start.
        req_valid_in = 2'b01;
        req_en_in = 2'b10;
        req_slot_in = {2'd1, 2'd2};
        push_rdy(2'b01);
        cyc();
        req_valid_in = 2'b00;
        frame_start_in = 1'b1;
        push_rdy(2'b00);
        push_commit(4'b1011, slots(b3, b2, b1, b0), 4, 1'b0);
        cyc();
        // Frame start held: ready stays low, commits repeat.
        req_valid_in = 2'b01;
        push_rdy(2'b00);
        push_commit(4'b1011, slots(b3, b2, b1, b0), 0, 1'b0);
        cyc();
        push_rdy(2'b00);
        push_commit(4'b1011, slots(b3, b2, b1, b0), 0, 1'b0);
        cyc();
        frame_start_in = 1'b0;
        req_valid_in = 2'b00;
        cyc();
        // Reset in the middle of a pending transfer.
        req_valid_in = 2'b10;
        req_en_in = 2'b11;
        req_slot_in = {2'd0, 2'd0};
        req_box_in = {bx(9, 9, 9, 9), bx(9, 9, 9, 9)};
        #2 rst_n_in = 1'b0;
        #1;
        chk("midrst_ready", 168'(req_ready_out), 168'(0));
        chk("midrst_valid", 168'(slot_valid_out), 168'(0));
        chk("midrst_box", slot_box_out, 168'(0));
        cyc();
        req_valid_in = 2'b00;
        #2 rst_n_in = 1'b1;
        cyc();
        frame_start_in = 1'b1;
        push_rdy(2'b00);
        push_commit(4'b0000, 168'(0), 0, 1'b0);
        cyc();
        frame_start_in = 1'b0;
        // Both requesters write slot 1 in one frame, then req0 writes slot 0.
        req_valid_in = 2'b11;
        req_slot_in = {2'd1, 2'd1};
        req_box_in = {bx(50, 60, 70, 80), bx(20, 30, 10, 40)};
        push_rdy(2'b01);
        cyc();
        req_valid_in = 2'b10;
        push_rdy(2'b10);
        cyc();
        req_valid_in = 2'b01;
        req_slot_in = {2'd1, 2'd0};
        req_box_in = {bx(50, 60, 70, 80), bx(2, 1, 1, 2)};
        push_rdy(2'b01);
        cyc();
        req_valid_in = 2'b00;
        frame_start_in = 1'b1;
        push_rdy(2'b00);
        push_commit(4'b0011, slots(42'(0), 42'(0), c1, c0), 3, 1'b1);
        cyc();
        frame_start_in = 1'b0;
        cyc();
        frame_start_in = 1'b1;
        push_rdy(2'b00);
        push_commit(4'b0011, slots(42'(0), 42'(0), c1, c0), 0, 1'b0);
        cyc();
        frame_start_in = 1'b0;
        repeat (3) cyc();
        chk("pending_ready", 168'(rq.size()), 168'(0));
        chk("pending_commit", 168'(cq.size()), 168'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
